// File: rtl/parallel_hps_single_pio_in_capture.sv
// Avalon-MM input PIO: synchronizes an asynchronous bus, captures per-bit edges
// into a sticky W1C register and drives a maskable level interrupt.
module parallel_hps_single_pio_in_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_COUNT = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [CW-1:0]    arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_next;

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign data_in = sync_q[SYNC_STAGES-1];
  assign armed   = (arm_cnt == ARM_COUNT);
  assign wr_en   = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      data_prev <= '0;
      arm_cnt   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      data_prev <= data_in;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = data_in & ~data_prev;
      1:       edge_raw = ~data_in & data_prev;
      default: edge_raw = data_in ^ data_prev;
    endcase
    edge_hit = armed ? edge_raw : '0;
    clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  end

  // Clear is applied before the set so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr_bits) | edge_hit;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = data_in;
      2'd2:    rd_next[WIDTH-1:0] = irq_mask;
      2'd3:    rd_next[WIDTH-1:0] = edge_cap;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_parallel_hps_single_pio_in_capture.sv
// Directed bench: a per-cycle vector table on a rising-edge instance, then
// hand sequences for async reset and an any-edge instance.
module tb_parallel_hps_single_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0;
  logic [7:0]  in_any;
  logic [31:0] rd0;
  logic [31:0] rd_any;
  logic        irq0;
  logic        irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parallel_hps_single_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0)
  );

  parallel_hps_single_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_any),
    .readdata(rd_any), .irq(irq_any)
  );

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  inp;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tv[$];

  task automatic v(input logic [1:0] a, input logic w, input logic [31:0] wd,
                   input logic [7:0] ip, input logic [31:0] r, input logic q);
    vec_t e;
    e.addr = a; e.wr = w; e.wdata = wd; e.inp = ip; e.rd = r; e.irq = q;
    tv.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] wd);
    address = a; chipselect = 1'b1; write_n = !w; writedata = wd;
  endtask

  task automatic idle;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = 2'd0;
  endtask

  initial begin
    // row format: addr, wr, wdata, in_port, readdata after edge, irq after edge
    v(0, 0, 0, 8'hFF, 32'h00, 0);  // reset exit with input high
    v(0, 0, 0, 8'hFF, 32'h00, 0);
    v(0, 0, 0, 8'hFF, 32'hFF, 0);
    v(3, 0, 0, 8'hFF, 32'h00, 0);  // no spurious capture
    v(2, 1, 32'hFFFF_FF08, 8'hF7, 32'h00, 0);
    v(2, 0, 0, 8'hF7, 32'h08, 0);  // upper mask bits dropped
    v(0, 0, 0, 8'hF7, 32'hF7, 0);  // falling bit3 ignored
    v(3, 0, 0, 8'hFF, 32'h00, 0);  // bit3 rises before this edge
    v(3, 0, 0, 8'hFF, 32'h00, 0);
    v(0, 0, 0, 8'hFF, 32'hFF, 1);  // capture at E+2
    v(3, 0, 0, 8'hFF, 32'h08, 1);
    v(3, 1, 32'h08, 8'hFF, 32'h08, 0);  // W1C drops irq
    v(3, 0, 0, 8'hFF, 32'h00, 0);
    v(3, 0, 0, 8'hFA, 32'h00, 0);
    v(3, 0, 0, 8'hFA, 32'h00, 0);
    v(3, 0, 0, 8'hFF, 32'h00, 0);
    v(3, 0, 0, 8'hFF, 32'h00, 0);
    v(3, 0, 0, 8'hFF, 32'h00, 0);  // cap=05, masked out
    v(3, 1, 32'h00, 8'hFF, 32'h05, 0);  // write 0 keeps bits
    v(3, 0, 0, 8'hFF, 32'h05, 0);
    v(3, 0, 0, 8'hF7, 32'h05, 0);
    v(3, 0, 0, 8'hF7, 32'h05, 0);
    v(3, 0, 0, 8'hF7, 32'h05, 0);
    v(3, 0, 0, 8'hFF, 32'h05, 0);
    v(3, 0, 0, 8'hFF, 32'h05, 0);
    v(3, 0, 0, 8'hFF, 32'h05, 1);  // cap=0D
    v(3, 0, 0, 8'hF7, 32'h0D, 1);
    v(3, 0, 0, 8'hF7, 32'h0D, 1);
    v(3, 0, 0, 8'hFF, 32'h0D, 1);
    v(3, 0, 0, 8'hFF, 32'h0D, 1);
    v(3, 1, 32'h08, 8'hFF, 32'h0D, 1);  // new edge coincides with clear
    v(3, 0, 0, 8'hFF, 32'h0D, 1);
    v(3, 1, 32'h0D, 8'hFF, 32'h0D, 0);
    v(3, 0, 0, 8'hFF, 32'h00, 0);
    v(0, 1, 32'h00, 8'hFF, 32'hFF, 0);  // DATA is read-only
    v(1, 1, 32'hFF, 8'hFF, 32'h00, 0);
    v(1, 0, 0, 8'hFF, 32'h00, 0);
    v(2, 0, 0, 8'hFF, 32'h08, 0);
    v(0, 0, 0, 8'hFF, 32'hFF, 0);

    reset_n = 1'b0; in0 = 8'hFF; in_any = 8'h00;
    idle();
    repeat (3) tick();
    check("reset rd", rd0, 32'h0);
    check("reset irq", {31'd0, irq0}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      bus(tv[i].addr, tv[i].wr, tv[i].wdata);
      in0 = tv[i].inp;
      tick();
      check($sformatf("row%0d rd", i), rd0, tv[i].rd);
      check($sformatf("row%0d irq", i), {31'd0, irq0}, {31'd0, tv[i].irq});
    end

    // Capture 0xA5, enable all, then reset asynchronously mid-cycle.
    idle();
    in0 = 8'h5A;
    repeat (3) tick();
    in0 = 8'hFF;
    repeat (3) tick();
    bus(2, 1, 32'hFF);
    tick();
    check("mask ff irq", {31'd0, irq0}, 32'h1);
    bus(3, 0, 0);
    tick();
    check("cap a5", rd0, 32'hA5);
    #2 reset_n = 1'b0;
    #1;
    check("async rst rd", rd0, 32'h0);
    check("async rst irq", {31'd0, irq0}, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus(1, 0, 0); tick(); check("post rst addr1", rd0, 32'h0);
    bus(2, 0, 0); tick(); check("post rst mask", rd0, 32'h0);
    bus(3, 0, 0); tick(); check("post rst cap", rd0, 32'h0);
    check("post rst irq", {31'd0, irq0}, 32'h0);

    // Any-edge instance: toggle bit0 up and down.
    idle();
    repeat (4) tick();
    in_any = 8'h01; repeat (3) tick();
    in_any = 8'h00; repeat (3) tick();
    bus(3, 0, 0); tick();
    check("any cap", rd_any, 32'h01);
    check("any irq masked", {31'd0, irq_any}, 32'h0);
    check("rise cap after reset high", rd0, 32'h0);
    bus(2, 1, 32'h01); tick();
    check("any irq unmask", {31'd0, irq_any}, 32'h1);
    check("rise irq unmask", {31'd0, irq0}, 32'h0);
    bus(3, 1, 32'h01); tick();
    check("any w1c", {31'd0, irq_any}, 32'h0);
    idle();
    in_any = 8'h01; repeat (3) tick();
    check("any rise", {31'd0, irq_any}, 32'h1);
    bus(3, 1, 32'h01); tick();
    check("any w1c 2", {31'd0, irq_any}, 32'h0);
    idle();
    in_any = 8'h00; repeat (3) tick();
    check("any fall", {31'd0, irq_any}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
